// File: rtl/shift_issue_stage.sv
// ---------------------------------------------------------------------------
// shift_issue_stage
//   Two-register issue stage for RV32 shift instructions (SLL/SRL/SRA and
//   their immediate forms). S1 holds the decoded operands and drives an
//   external combinational barrel shifter; S2 captures the shifter result
//   and presents it on a valid/ready output port.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   inValid / inReady         request handshake
//   funct3, funct7b5, isImm   instruction decode fields
//   rs1Data, rs2Data          register operands (only rs2Data[4:0] used)
//   immShamt, rdAddr          immediate shift amount, destination register
//   shDataIn/shAmount/
//   shLeft/shArith            shifter controls, driven only from S1
//   shResult                  combinational shifter return
//   outValid / outReady       result handshake
//   outData, outRd, outIllegal result, destination, unsupported-encoding flag
//   shiftCount                completed legal shifts (only with the macro)
//
// Optional feature macro: SHIFT_PERF_CNT_EN (adds shiftCount counter).
// ---------------------------------------------------------------------------
module shift_issue_stage (
  input  logic        clk,
  input  logic        rst,
`ifdef SHIFT_PERF_CNT_EN
  output logic [31:0] shiftCount,
`endif
  input  logic        inValid,
  output logic        inReady,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        isImm,
  input  logic [31:0] rs1Data,
  input  logic [31:0] rs2Data,
  input  logic [4:0]  immShamt,
  input  logic [4:0]  rdAddr,
  output logic [31:0] shDataIn,
  output logic [4:0]  shAmount,
  output logic        shLeft,
  output logic        shArith,
  input  logic [31:0] shResult,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] outData,
  output logic [4:0]  outRd,
  output logic        outIllegal
);

  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_data_q, s1_data_d;
  logic [4:0]  s1_amt_q, s1_amt_d;
  logic        s1_left_q, s1_left_d;
  logic        s1_arith_q, s1_arith_d;
  logic [4:0]  s1_rd_q, s1_rd_d;
  logic        s1_ill_q, s1_ill_d;

  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_data_q, s2_data_d;
  logic [4:0]  s2_rd_q, s2_rd_d;
  logic        s2_ill_q, s2_ill_d;

  logic        dec_legal_s, dec_left_s, dec_arith_s;
  logic [4:0]  amt_s;
  logic        s2_free_s, accept_s, move_s;
  logic        unused_s;

  // Upper rs2 bits never affect a shift.
  assign unused_s = ^rs2Data[31:5];

  // Handshake: readiness never looks at inValid.
  assign s2_free_s = !s2_valid_q || outReady;
  assign inReady   = !s1_valid_q || s2_free_s;
  assign accept_s  = inValid && inReady;
  assign move_s    = s1_valid_q && s2_free_s;

  assign amt_s = isImm ? immShamt : rs2Data[4:0];

  // Decode funct3/funct7b5 into shift direction/type and legality.
  always_comb begin
    dec_legal_s = 1'b0;
    dec_left_s  = 1'b0;
    dec_arith_s = 1'b0;
    case (funct3)
      3'b001: begin
        if (!funct7b5) begin
          dec_legal_s = 1'b1;
          dec_left_s  = 1'b1;
        end else begin
          dec_legal_s = 1'b0;
        end
      end
      3'b101: begin
        dec_legal_s = 1'b1;
        dec_arith_s = funct7b5;
      end
      default: begin
        dec_legal_s = 1'b0;
      end
    endcase
  end

  // Next-state for both pipeline registers.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_amt_d   = s1_amt_q;
    s1_left_d  = s1_left_q;
    s1_arith_d = s1_arith_q;
    s1_rd_d    = s1_rd_q;
    s1_ill_d   = s1_ill_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_rd_d    = s2_rd_q;
    s2_ill_d   = s2_ill_q;

    if (accept_s) begin
      // Illegal encodings park the shifter with all-zero controls.
      s1_valid_d = 1'b1;
      s1_data_d  = dec_legal_s ? rs1Data : 32'h0000_0000;
      s1_amt_d   = dec_legal_s ? amt_s : 5'd0;
      s1_left_d  = dec_left_s;
      s1_arith_d = dec_arith_s;
      s1_rd_d    = rdAddr;
      s1_ill_d   = !dec_legal_s;
    end else if (move_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (move_s) begin
      s2_valid_d = 1'b1;
      s2_data_d  = s1_ill_q ? 32'h0000_0000 : shResult;
      s2_rd_d    = s1_rd_q;
      s2_ill_d   = s1_ill_q;
    end else if (outReady) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= 32'h0000_0000;
      s1_amt_q   <= 5'd0;
      s1_left_q  <= 1'b0;
      s1_arith_q <= 1'b0;
      s1_rd_q    <= 5'd0;
      s1_ill_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= 32'h0000_0000;
      s2_rd_q    <= 5'd0;
      s2_ill_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_amt_q   <= s1_amt_d;
      s1_left_q  <= s1_left_d;
      s1_arith_q <= s1_arith_d;
      s1_rd_q    <= s1_rd_d;
      s1_ill_q   <= s1_ill_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_rd_q    <= s2_rd_d;
      s2_ill_q   <= s2_ill_d;
    end
  end

  assign shDataIn   = s1_data_q;
  assign shAmount   = s1_amt_q;
  assign shLeft     = s1_left_q;
  assign shArith    = s1_arith_q;
  assign outValid   = s2_valid_q;
  assign outData    = s2_data_q;
  assign outRd      = s2_rd_q;
  assign outIllegal = s2_ill_q;

`ifdef SHIFT_PERF_CNT_EN
  logic [31:0] cnt_q;

  // Count legal results leaving the stage; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 32'h0000_0000;
    end else if (s2_valid_q && outReady && !s2_ill_q) begin
      cnt_q <= cnt_q + 32'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign shiftCount = cnt_q;
`endif

endmodule
